// File: rtl/ha_token_rx.sv
// Receive side of the 32-bit HA token link. Tokens are buffered in a
// first-word-fall-through FIFO and one credit is returned per token consumed.
module ha_token_rx #(
    parameter int DataIn_1_BW = 32,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DataIn_1_BW-1:0] DataIn_1,
    input  logic                   DataIn_1_valid,
    output logic                   credit_ret,
    output logic [DataIn_1_BW-1:0] DataOut_1,
    output logic                   DataOut_1_valid,
    input  logic                   DataOut_1_ready,
    output logic [CNT_W-1:0]       occupancy,
    output logic                   overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                   rstMeta_p0;
    logic                   rstSync_p1;
    logic                   rstInt_n;
    logic [DataIn_1_BW-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wrPtr;
    logic [PTR_W-1:0]       rdPtr;
    logic [CNT_W-1:0]       occCnt;
    logic                   creditRet_p1;
    logic                   overflowErr;
    logic                   isFull;
    logic                   notEmpty;
    logic                   doPush;
    logic                   doPop;

    // Reset asserts immediately but releases two clk edges after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstMeta_p0 <= 1'b0;
            rstSync_p1 <= 1'b0;
        end else begin
            rstMeta_p0 <= 1'b1;
            rstSync_p1 <= rstMeta_p0;
        end
    end

    assign rstInt_n = rstSync_p1;

    assign isFull   = (occCnt == CNT_W'(DEPTH));
    assign notEmpty = (occCnt != '0);
    assign doPop    = notEmpty & DataOut_1_ready;
    // When full, a same-cycle pop frees the slot the new token lands in.
    assign doPush   = DataIn_1_valid & (~isFull | doPop);

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= DataIn_1;
        end
    end

    always_ff @(posedge clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            occCnt       <= '0;
            creditRet_p1 <= 1'b0;
            overflowErr  <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   occCnt <= occCnt + CNT_W'(1);
                2'b01:   occCnt <= occCnt - CNT_W'(1);
                default: occCnt <= occCnt;
            endcase
            creditRet_p1 <= doPop;
            if (DataIn_1_valid && isFull && !doPop) begin
                overflowErr <= 1'b1;
            end
        end
    end

    // Output is forced to zero while empty so reset and idle present a clean bus.
    assign DataOut_1       = notEmpty ? mem[rdPtr] : '0;
    assign DataOut_1_valid = notEmpty;
    assign occupancy       = occCnt;
    assign credit_ret      = creditRet_p1;
    assign overflow_err    = overflowErr;

endmodule

// File: tb/tb_ha_token_rx.sv
// Directed and randomized self-checking bench for ha_token_rx (DEPTH=4).
module tb_ha_token_rx;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] DataIn_1;
    logic        DataIn_1_valid;
    logic        credit_ret;
    logic [31:0] DataOut_1;
    logic        DataOut_1_valid;
    logic        DataOut_1_ready;
    logic [2:0]  occupancy;
    logic        overflow_err;

    int nChecks = 0;
    int nErrors = 0;

    ha_token_rx #(.DataIn_1_BW(32), .DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .DataIn_1       (DataIn_1),
        .DataIn_1_valid (DataIn_1_valid),
        .credit_ret     (credit_ret),
        .DataOut_1      (DataOut_1),
        .DataOut_1_valid(DataOut_1_valid),
        .DataOut_1_ready(DataOut_1_ready),
        .occupancy      (occupancy),
        .overflow_err   (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic pushTok(input logic [31:0] d);
        DataIn_1       = d;
        DataIn_1_valid = 1'b1;
        tick();
        DataIn_1_valid = 1'b0;
    endtask

    task automatic drainExpect(input string tag, input logic [31:0] d);
        DataOut_1_ready = 1'b1;
        chk({tag, "_data"}, DataOut_1, d);
        chk({tag, "_vld"}, 32'(DataOut_1_valid), 32'd1);
        tick();
        chk({tag, "_cred"}, 32'(credit_ret), 32'd1);
        DataOut_1_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] expQ[$];
        int          cred;
        int          sent;
        int          rcvd;
        int          cyc;
        int          pulses;
        logic [31:0] d;

        rst             = 1'b0;
        DataIn_1        = '0;
        DataIn_1_valid  = 1'b0;
        DataOut_1_ready = 1'b0;

        // Reset held for 3 cycles, then idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_occ", 32'(occupancy), 32'd0);
            chk("rst_vld", 32'(DataOut_1_valid), 32'd0);
            chk("rst_cred", 32'(credit_ret), 32'd0);
            chk("rst_ovf", 32'(overflow_err), 32'd0);
            chk("rst_data", DataOut_1, 32'd0);
        end
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (credit_ret || DataOut_1_valid || occupancy != 0 || DataOut_1 != 0 || overflow_err)
                pulses++;
        end
        chk("idle_quiet", 32'(pulses), 32'd0);

        // Fill with ready low.
        for (int i = 1; i <= 4; i++) begin
            pushTok(32'hA000_0000 + 32'(i));
            chk("fill_occ", 32'(occupancy), 32'(i));
            chk("fill_head", DataOut_1, 32'hA000_0001);
        end
        chk("fill_ovf", 32'(overflow_err), 32'd0);

        // Drain: one credit per pop, lagging by one edge.
        for (int i = 1; i <= 4; i++) begin
            drainExpect("drain", 32'hA000_0000 + 32'(i));
            chk("drain_occ", 32'(occupancy), 32'(4 - i));
        end
        tick();
        chk("drain_cred_end", 32'(credit_ret), 32'd0);
        chk("drain_vld_end", 32'(DataOut_1_valid), 32'd0);

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) pushTok(32'hA000_0000 + 32'(i));
        chk("fpp_occ0", 32'(occupancy), 32'd4);
        DataIn_1        = 32'h0000_00B5;
        DataIn_1_valid  = 1'b1;
        DataOut_1_ready = 1'b1;
        chk("fpp_head", DataOut_1, 32'hA000_0001);
        tick();
        DataIn_1_valid  = 1'b0;
        DataOut_1_ready = 1'b0;
        chk("fpp_occ", 32'(occupancy), 32'd4);
        chk("fpp_ovf", 32'(overflow_err), 32'd0);
        chk("fpp_cred", 32'(credit_ret), 32'd1);
        drainExpect("fpp", 32'hA000_0002);
        drainExpect("fpp", 32'hA000_0003);
        drainExpect("fpp", 32'hA000_0004);
        drainExpect("fpp", 32'h0000_00B5);
        chk("fpp_occ_end", 32'(occupancy), 32'd0);

        // Overflow: push into a full FIFO with no pop.
        for (int i = 1; i <= 4; i++) pushTok(32'hC000_0000 + 32'(i));
        tick();
        pushTok(32'h0000_DEAD);
        chk("ovf_occ", 32'(occupancy), 32'd4);
        chk("ovf_flag", 32'(overflow_err), 32'd1);
        chk("ovf_cred", 32'(credit_ret), 32'd0);
        tick();
        tick();
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        for (int i = 1; i <= 4; i++) drainExpect("ovf", 32'hC000_0000 + 32'(i));
        chk("ovf_vld_end", 32'(DataOut_1_valid), 32'd0);
        chk("ovf_sticky2", 32'(overflow_err), 32'd1);

        // Random traffic from a credit-limited sender.
        doReset();
        chk("rnd_ovf_clr", 32'(overflow_err), 32'd0);
        cred = DEPTH;
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while ((sent < 1000 || rcvd < 1000) && cyc < 20000) begin
            chk("inv", 32'(cred + int'(occupancy) + int'(credit_ret)), 32'(DEPTH));
            if (credit_ret) cred++;
            DataOut_1_ready = ($urandom_range(0, 2) != 0);
            if (DataOut_1_valid && DataOut_1_ready) begin
                if (expQ.size() == 0) chk("rnd_spurious", DataOut_1, 32'hFFFF_FFFF);
                else chk("rnd_data", DataOut_1, expQ.pop_front());
                rcvd++;
            end
            if (sent < 1000 && cred > 0 && $urandom_range(0, 3) != 0) begin
                d              = $urandom;
                DataIn_1       = d;
                DataIn_1_valid = 1'b1;
                expQ.push_back(d);
                cred--;
                sent++;
            end else begin
                DataIn_1_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        DataIn_1_valid  = 1'b0;
        DataOut_1_ready = 1'b0;
        chk("rnd_done", 32'(rcvd), 32'd1000);
        chk("rnd_ovf", 32'(overflow_err), 32'd0);

        // Asynchronous reset between edges with three tokens buffered.
        tick();
        for (int i = 1; i <= 3; i++) pushTok(32'hD000_0000 + 32'(i));
        chk("mid_occ", 32'(occupancy), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_occ_now", 32'(occupancy), 32'd0);
        chk("mid_vld_now", 32'(DataOut_1_valid), 32'd0);
        chk("mid_data_now", DataOut_1, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (credit_ret) pulses++;
        end
        chk("mid_nocred", 32'(pulses), 32'd0);
        pushTok(32'hE000_0001);
        chk("mid_new_vld", 32'(DataOut_1_valid), 32'd1);
        pushTok(32'hE000_0002);
        chk("mid_new_occ", 32'(occupancy), 32'd2);
        drainExpect("mid", 32'hE000_0001);
        drainExpect("mid", 32'hE000_0002);
        chk("mid_end_occ", 32'(occupancy), 32'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/ha_token_rx.md
Name: ha_token_rx

Overview:
- Receiving end of the 32-bit HA token link; counterpart to the token transmitter that drives the wrapper chain.
- Accepts tokens from the sender under credit-based flow control and buffers them in a small FIFO.
- Presents buffered tokens downstream on a valid/ready stream.
- Returns one credit to the sender for every token consumed downstream.

Parameters:
- DataIn_1_BW, 32, token data width.
- DEPTH, 4, FIFO entries and initial sender credit count; power of two, 2..16.
- CNT_W, 3, occupancy counter width; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- DataIn_1  input  DataIn_1_BW  token data from sender.
- DataIn_1_valid  input  1  sender asserts for one cycle per token; no ready (credit-guaranteed).
- credit_ret  output  1  one-cycle pulse = one credit returned to sender.
- DataOut_1  output  DataIn_1_BW  head-of-FIFO token.
- DataOut_1_valid  output  1  FIFO non-empty.
- DataOut_1_ready  input  1  downstream accepts the head token.
- occupancy  output  CNT_W  current entry count, 0..DEPTH.
- overflow_err  output  1  sticky; set when a token arrives with no free slot.

Behaviour:
- Reset (rst=0, async) clears pointers, occupancy=0, DataOut_1_valid=0, DataOut_1=0, credit_ret=0, overflow_err=0.
  - Deassertion is synchronised internally: two flops, release on the clk edge.
  - Reset mid-operation discards all buffered tokens and any pending credit. The sender must be reset together so both ends restart at DEPTH credits.
- Push: DataIn_1_valid=1 at a clk edge writes DataIn_1 at the write pointer and increments it, unless the FIFO is full with no simultaneous pop.
- Pop: DataOut_1_valid && DataOut_1_ready at a clk edge increments the read pointer.
- Pointers wrap modulo DEPTH. Full/empty are derived from occupancy, not from pointer equality.
- Output is first-word-fall-through: DataOut_1 = mem[rd_ptr] (combinational read of a registered array).
  - DataOut_1_valid = (occupancy != 0).
  - Latency: token pushed at edge N is visible on DataOut_1 with valid=1 after edge N when the FIFO was empty (1 cycle).
  - DataOut_1 is held stable while valid=1 and ready=0.
- Occupancy update: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- Full (occupancy=DEPTH) with push and pop in the same cycle:
  - Both are accepted; occupancy stays DEPTH.
  - The pushed token lands in the slot vacated this cycle.
  - overflow_err is not set.
- Full with push and no pop:
  - The token is dropped; pointers and occupancy are unchanged.
  - overflow_err is set and held until reset.
  - No credit is generated.
- Empty with push and ready=1 in the same cycle: no bypass. The token appears the next cycle.
  - A pop is impossible while empty because valid=0.
- Credit return:
  - credit_ret is registered: it pulses high for exactly one cycle, the cycle after each pop edge.
  - Back-to-back pops give consecutive high cycles; exactly one pulse per popped token.
  - Dropped tokens never return credit.
- Credit invariant for a compliant sender: sender credits + occupancy + pending credit_ret = DEPTH at every edge.
- No combinational path from DataIn_1_valid to any output. DataOut_1_ready affects only state, never same-cycle outputs.

Test Plan:
- Reset/idle: rst=0 for 3 cycles then release. Required: occupancy=0, valid=0, credit_ret=0, overflow_err=0, DataOut_1=0 throughout, and no pulses for 20 idle cycles.
- Fill and drain (DEPTH=4): push 0xA0000001..0xA0000004 on consecutive cycles with ready=0.
  - Required: occupancy steps 1..4, DataOut_1=0xA0000001.
  - Then ready=1 for 4 cycles: outputs appear in order, credit_ret high on 4 consecutive cycles each lagging its pop by 1, occupancy ends at 0.
- Full push+pop: with FIFO full, push 0xB5 while ready=1. Required: 0xA0000001 popped, occupancy stays 4, overflow_err=0, 0xB5 emerges after 0xA0000004.
- Overflow: with FIFO full and ready=0, push 0xDEAD. Required: occupancy=4, overflow_err=1 and stays 1, no credit_ret, and 0xDEAD is never output.
- Wrap-around and backpressure: 1000 random tokens with random push (credit-limited sender model) and random ready.
  - Required: output sequence equals input sequence and the credit invariant holds every cycle.
  - Pointers wrap at least 200 times.
- Reset mid-operation: occupancy=3, assert rst asynchronously between edges. Required: valid and occupancy drop to 0 immediately, no credit_ret after release, and new tokens flow normally.
